// File: rtl/bus_debug_pkg.sv
// -----------------------------------------------------------------------------
// bus_debug_pkg
// Shared definitions for the board-side bus debug block:
//   - dbg_state_e : clock FSM state encoding
//   - TICK_CNT_W  : width of the running tick counter
//   - page_w()    : page-select width for a given channel count (minimum 1)
// -----------------------------------------------------------------------------
package bus_debug_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_STEP_IDLE = 2'b01,
    ST_STEP_HIGH = 2'b10,
    ST_UNUSED    = 2'b11
  } dbg_state_e;

  localparam int TICK_CNT_W = 16;

  // Two channels per page, so the page index covers num_ch/2 values.
  function automatic int page_w(input int num_ch);
    int pages;
    pages = num_ch / 2;
    if (pages <= 2) return 1;
    return $clog2(pages);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Synchronises a raw active-low push button and accepts a new level only after
// DEBOUNCE_CYCLES consecutive synchronised samples that differ from the
// current debounced level. A press is the falling edge of the debounced level.
// Ports:
//   clk     in   board clock
//   reset   in   asynchronous, active-high
//   key_raw in   raw key, active-low, asynchronous to clk
//   key_db  out  debounced level (1 = released)
//   press   out  one-cycle pulse on each debounced 1->0 transition
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_db,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of differing samples already seen; the sample that
  // brings the run to DEBOUNCE_CYCLES is the one that flips the level.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser resets to the released level so reset release is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign key_db = db_q;
  assign press  = db_dly_q & ~db_q;

endmodule

// File: rtl/bus_debug_clock_monitor.sv
// -----------------------------------------------------------------------------
// bus_debug_clock_monitor
// Programmable divided bus clock (free-run or debounced single-step) plus a
// paged two-channel probe viewer with optional auto-scroll.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   ST_RUN       | free-running divider, clk_out toggles every div_sel+1
//   ST_STEP_IDLE | single-step, clk_out low, waiting for a key press
//   ST_STEP_HIGH | single-step, clk_out high for div_sel+1 enabled cycles
//   ST_UNUSED    | illegal, recovers to ST_RUN
//
// Ports:
//   clk, reset        board clock, async active-high reset
//   ena               clock enable for divider and step presses
//   mode              0 = free-run, 1 = single-step
//   div_sel           half period minus one, in clk cycles
//   step_key          raw active-low step key
//   page_auto         1 = auto-scroll pages every SCROLL_TICKS ticks
//   page_sel          manual page select
//   probe_bus         NUM_CH channels of CH_WIDTH bits, ch0 in the LSBs
//   clk_out, tick     bus clock and its rising-edge pulse
//   tick_count        wrapping tick counter
//   key_db            debounced key level
//   state_out         FSM state
//   page_cur          displayed page, page_valid, disp_data {ch[2p+1],ch[2p]}
// -----------------------------------------------------------------------------
module bus_debug_clock_monitor
  import bus_debug_pkg::*;
#(
  parameter int DIV_WIDTH       = 26,
  parameter int NUM_CH          = 8,
  parameter int CH_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCROLL_TICKS    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ena,
  input  logic                         mode,
  input  logic [DIV_WIDTH-1:0]         div_sel,
  input  logic                         step_key,
  input  logic                         page_auto,
  input  logic [page_w(NUM_CH)-1:0]    page_sel,
  input  logic [NUM_CH*CH_WIDTH-1:0]   probe_bus,
  output logic                         clk_out,
  output logic                         tick,
  output logic [TICK_CNT_W-1:0]        tick_count,
  output logic                         key_db,
  output logic [1:0]                   state_out,
  output logic [page_w(NUM_CH)-1:0]    page_cur,
  output logic                         page_valid,
  output logic [2*CH_WIDTH-1:0]        disp_data
);

  localparam int PAGE_W    = page_w(NUM_CH);
  localparam int NUM_PAGES = NUM_CH / 2;
  localparam int SC_W      = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [PAGE_W:0]   NUM_PAGES_W = (PAGE_W + 1)'(NUM_PAGES);
  localparam logic [PAGE_W-1:0] PAGE_LAST   = PAGE_W'(NUM_PAGES - 1);
  localparam logic [SC_W-1:0]   SCROLL_LAST = SC_W'(SCROLL_TICKS - 1);

  logic press;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk    (clk),
    .reset  (reset),
    .key_raw(step_key),
    .key_db (key_db),
    .press  (press)
  );

  // ---------------------------------------------------------------------------
  // Divider / clock FSM
  // ---------------------------------------------------------------------------
  dbg_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  clk_out_q, clk_out_d;
  logic                  tick_q, tick_d;
  logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode && !clk_out_q) begin
          state_d = ST_STEP_IDLE;
          cnt_d   = '0;
        end else if (ena) begin
          if (cnt_q == div_sel) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
            // A pending step request lets the high phase finish first.
            if (mode) state_d = ST_STEP_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_STEP_IDLE: begin
        clk_out_d = 1'b0;
        if (!mode) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (press && ena) begin
          state_d   = ST_STEP_HIGH;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_STEP_HIGH: begin
        clk_out_d = 1'b1;
        if (ena) begin
          if (cnt_q == div_sel) begin
            state_d   = ST_STEP_IDLE;
            clk_out_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_RUN;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
    // Counted off the registered pulse, so the count lags tick by one cycle.
    tick_count_d = tick_q ? tick_count_q + 1'b1 : tick_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pager
  // ---------------------------------------------------------------------------
  logic [PAGE_W-1:0]     page_cur_q, page_cur_d;
  logic                  page_valid_q, page_valid_d;
  logic [SC_W-1:0]       scroll_q, scroll_d;
  logic [2*CH_WIDTH-1:0] disp_data_q, disp_data_d;
  logic [2*CH_WIDTH-1:0] page_data;

  always_comb begin
    page_cur_d   = page_cur_q;
    page_valid_d = page_valid_q;
    scroll_d     = scroll_q;
    if (page_auto) begin
      page_valid_d = 1'b1;
      if (tick_q) begin
        if (scroll_q == SCROLL_LAST) begin
          scroll_d   = '0;
          page_cur_d = (page_cur_q == PAGE_LAST) ? '0 : page_cur_q + 1'b1;
        end else begin
          scroll_d = scroll_q + 1'b1;
        end
      end
    end else begin
      scroll_d = '0;
      if ({1'b0, page_sel} < NUM_PAGES_W) begin
        page_cur_d   = page_sel;
        page_valid_d = 1'b1;
      end else begin
        page_valid_d = 1'b0;
      end
    end

    // Select from the next page so disp_data and page_cur update together.
    page_data = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (page_cur_d == PAGE_W'(p)) page_data = probe_bus[p*2*CH_WIDTH +: 2*CH_WIDTH];
    end
    disp_data_d = page_valid_d ? page_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_cur_q   <= '0;
      page_valid_q <= 1'b1;
      scroll_q     <= '0;
      disp_data_q  <= '0;
    end else begin
      page_cur_q   <= page_cur_d;
      page_valid_q <= page_valid_d;
      scroll_q     <= scroll_d;
      disp_data_q  <= disp_data_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign state_out  = state_q;
  assign page_cur   = page_cur_q;
  assign page_valid = page_valid_q;
  assign disp_data  = disp_data_q;

endmodule
